// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready handshake; one binary move stage per shift bit.
// Define BARREL_SHIFTER_ARITH_EN to compile sign-fill for select=10 (otherwise it behaves as a logical shift).
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       select,
  input  logic             direction,
  input  logic [SHW-1:0]   shift_value,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out
);

  // Stage registers; stage 0 is nearest the input and moves by 2^(SHW-1).
  logic             v_q   [SHW];
  logic [WIDTH-1:0] d_q   [SHW];
  logic             c_q   [SHW];
  logic             rot_q [SHW];
  logic             dir_q [SHW];
  logic [SHW-1:0]   amt_q [SHW];

  // Values presented to each stage's register input.
  logic             sv    [SHW];
  logic [WIDTH-1:0] sd    [SHW];
  logic             sc    [SHW];
  logic             srot  [SHW];
  logic             sdir  [SHW];
  logic [SHW-1:0]   samt  [SHW];
  logic [WIDTH-1:0] d_n   [SHW];
  logic             c_n   [SHW];
  logic             take  [SHW];

`ifdef BARREL_SHIFTER_ARITH_EN
  logic             ari_q [SHW];
  logic             sari  [SHW];
`endif

  function automatic logic bit_of(input logic [WIDTH-1:0] d, input int unsigned pos);
    logic [WIDTH-1:0] t;
    t = d >> pos;
    return t[0];
  endfunction

  // A stage loads when it, or every stage downstream of it up to an empty one, can move;
  // accumulating from the output end avoids a combinational self-reference on take[].
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int unsigned j = 0; j < SHW; j++) begin
      acc = acc || !v_q[SHW-1-j];
      take[SHW-1-j] = acc;
    end
  end

  assign in_ready = !reset && take[0];

  always_comb begin
    sv[0]   = in_valid && in_ready;
    sd[0]   = din;
    sc[0]   = 1'b0;
    srot[0] = (select == 2'b01);
    sdir[0] = direction;
    samt[0] = shift_value;
`ifdef BARREL_SHIFTER_ARITH_EN
    sari[0] = (select == 2'b10);
`endif
    for (int unsigned i = 1; i < SHW; i++) begin
      sv[i]   = v_q[i-1];
      sd[i]   = d_q[i-1];
      sc[i]   = c_q[i-1];
      srot[i] = rot_q[i-1];
      sdir[i] = dir_q[i-1];
      samt[i] = amt_q[i-1];
`ifdef BARREL_SHIFTER_ARITH_EN
      sari[i] = ari_q[i-1];
`endif
    end
  end

  always_comb begin
    int unsigned k;
    int unsigned s;
    logic        fill;
    logic [SHW-1:0] amt_sh;
    for (int unsigned i = 0; i < SHW; i++) begin
      k      = SHW - 1 - i;
      s      = 32'd1 << k;
      amt_sh = samt[i] >> k;
`ifdef BARREL_SHIFTER_ARITH_EN
      fill   = sari[i] & sd[i][WIDTH-1];
`else
      fill   = 1'b0;
`endif
      d_n[i] = sd[i];
      c_n[i] = sc[i];
      if (amt_sh[0]) begin
        if (sdir[i]) begin
          d_n[i] = srot[i] ? ((sd[i] << s) | (sd[i] >> (WIDTH - s))) : (sd[i] << s);
          c_n[i] = srot[i] ? 1'b0 : bit_of(sd[i], WIDTH - s);
        end else begin
          d_n[i] = srot[i] ? ((sd[i] >> s) | (sd[i] << (WIDTH - s)))
                           : ((sd[i] >> s) | ({WIDTH{fill}} << (WIDTH - s)));
          c_n[i] = srot[i] ? 1'b0 : bit_of(sd[i], s - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SHW; i++) begin
        v_q[i]   <= 1'b0;
        d_q[i]   <= '0;
        c_q[i]   <= 1'b0;
        rot_q[i] <= 1'b0;
        dir_q[i] <= 1'b0;
        amt_q[i] <= '0;
`ifdef BARREL_SHIFTER_ARITH_EN
        ari_q[i] <= 1'b0;
`endif
      end
    end else begin
      for (int unsigned i = 0; i < SHW; i++) begin
        if (take[i]) begin
          v_q[i]   <= sv[i];
          d_q[i]   <= d_n[i];
          c_q[i]   <= c_n[i];
          rot_q[i] <= srot[i];
          dir_q[i] <= sdir[i];
          amt_q[i] <= samt[i];
`ifdef BARREL_SHIFTER_ARITH_EN
          ari_q[i] <= sari[i];
`endif
        end
      end
    end
  end

  assign out_valid = v_q[SHW-1];
  assign dout      = d_q[SHW-1];
  assign carry_out = c_q[SHW-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=8); honours BARREL_SHIFTER_ARITH_EN in its model.
module tb_pipelined_barrel_shifter;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    select;
  logic          direction;
  logic [SW-1:0] shift_value;
  logic [W-1:0]  din;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout;
  logic          carry_out;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .direction(direction), .shift_value(shift_value), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    int unsigned  acc;
    bit           lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          acc_count = 0;
  int          pops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference model: result bit i taken straight from its source position in din.
  function automatic void model(input logic [W-1:0] d, input logic [1:0] s, input logic dir,
                                input logic [SW-1:0] n_in, output logic [W-1:0] r, output logic c);
    int  n;
    bit  rot;
    bit  ari;
    n   = int'(n_in);
    rot = (s == 2'b01);
`ifdef BARREL_SHIFTER_ARITH_EN
    ari = (s == 2'b10);
`else
    ari = 1'b0;
`endif
    r = '0;
    c = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (rot) r[i] = dir ? d[(i - n + W) % W] : d[(i + n) % W];
      else if (dir) r[i] = (i >= n) ? d[i - n] : 1'b0;
      else r[i] = (i + n < W) ? d[i + n] : (ari ? d[W-1] : 1'b0);
    end
    if (!rot && n != 0) c = dir ? d[W - n] : d[n - 1];
  endfunction

  // Monitor: pops on every output transfer, checks held output during stalls.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h required=none at cycle %0d", dout, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("dout", 32'(dout), 32'(e.d));
          check("carry_out", 32'(carry_out), 32'(e.c));
          if (e.lat) check("latency", cyc + 1 - e.acc, SW);
          pops++;
        end
      end else if (q.size() > 0) begin
        check("stall_dout", 32'(dout), 32'(q[0].d));
        check("stall_carry", 32'(carry_out), 32'(q[0].c));
      end
    end
  end

  task automatic issue(input logic [1:0] s, input logic dir, input logic [SW-1:0] n,
                       input logic [W-1:0] d, input logic [W-1:0] ed, input logic ec, input bit lat);
    bit done;
    done        = 1'b0;
    select      = s;
    direction   = dir;
    shift_value = n;
    din         = d;
    in_valid    = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.d = ed; e.c = ec; e.acc = cyc + 1; e.lat = lat;
        q.push_back(e);
        acc_count++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1 at cycle %0d", cyc);
    end
  endtask

  task automatic issue_rand(input bit lat);
    logic [1:0]    s;
    logic          dir;
    logic [SW-1:0] n;
    logic [W-1:0]  d;
    logic [W-1:0]  r;
    logic          c;
    s   = 2'($urandom_range(0, 3));
    dir = 1'($urandom_range(0, 1));
    n   = SW'($urandom_range(0, W - 1));
    d   = W'($urandom);
    model(d, s, dir, n, r, c);
    issue(s, dir, n, d, r, c, lat);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(posedge clk); #1;
      ok = (q.size() == 0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
    end
  endtask

  initial begin
    logic [W-1:0] arith_exp;
    int base;
    int pops0;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    select = '0; direction = 1'b0; shift_value = '0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_dout", 32'(dout), 0);
    check("reset_carry", 32'(carry_out), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Directed cases on din=8'h96.
    issue(2'b00, 1'b1, 3'd1, 8'h96, 8'h2C, 1'b1, 1'b1); drain();
    issue(2'b01, 1'b1, 3'd3, 8'h96, 8'hB4, 1'b0, 1'b1); drain();
    issue(2'b01, 1'b0, 3'd7, 8'h96, 8'h2D, 1'b0, 1'b1); drain();
    issue(2'b00, 1'b0, 3'd2, 8'h96, 8'h25, 1'b1, 1'b1); drain();
`ifdef BARREL_SHIFTER_ARITH_EN
    arith_exp = 8'hE5;
`else
    arith_exp = 8'h25;
`endif
    issue(2'b10, 1'b0, 3'd2, 8'h96, arith_exp, 1'b1, 1'b1); drain();
    issue(2'b11, 1'b1, 3'd1, 8'h96, 8'h2C, 1'b1, 1'b1); drain();
    issue(2'b00, 1'b1, 3'd0, 8'h96, 8'h96, 1'b0, 1'b1); drain();
    issue(2'b10, 1'b1, 3'd4, 8'h96, 8'h60, 1'b1, 1'b1); drain();

    // Back-pressure: five back-to-back requests with the sink stalled.
    out_ready = 1'b0;
    base = acc_count;
    fork
      begin
        for (int i = 0; i < 5; i++) issue_rand(1'b0);
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(posedge clk); #1;
          seen = (acc_count - base >= 3);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", 32'(acc_count - base), 3);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        @(posedge clk); #1;
        pops0 = pops;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("bp_burst_pops", 32'(pops - pops0), 5);
      end
    join
    drain();

    // Reset with two operations in flight.
    issue_rand(1'b0);
    issue_rand(1'b0);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_dout", 32'(dout), 0);
    check("midrst_carry", 32'(carry_out), 0);
    repeat (8) @(posedge clk);
    #1;
    issue(2'b00, 1'b1, 3'd1, 8'h96, 8'h2C, 1'b1, 1'b1); drain();

    // Random traffic with random sink stalls.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          issue_rand(1'b0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        for (int t = 0; t < 300; t++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
